// File: rtl/uart_echo_buffer.sv
// Receive-to-transmit echo buffer: a byte FIFO drained into the UART transmitter
// through its send/ready handshake, with optional CR -> CR LF expansion.
module uart_echo_buffer #(
    parameter int   DEPTH_LOG2 = 4,
    parameter logic CR_EXPAND  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  tx_send,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_HOLD     = 2'b01,
        ST_WAIT_RDY = 2'b10,
        ST_SEND_LF  = 2'b11
    } state_t;

    state_t                  state_r, state_s;
    logic [7:0]              mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_r, rd_ptr_r;
    logic [DEPTH_LOG2:0]     count_r;
    logic                    overflow_r;
    logic                    tx_send_r, tx_send_s;
    logic [7:0]              tx_data_r, tx_data_s;
    logic                    lf_done_r, lf_done_s;
    logic                    full_s, empty_s, pop_s, push_s, drop_s;

    assign full_s  = (count_r == FULL_COUNT);
    assign empty_s = (count_r == {(DEPTH_LOG2+1){1'b0}});
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_s  = rx_valid & (~full_s | pop_s);
    assign drop_s  = rx_valid & full_s & ~pop_s;

    assign tx_send    = tx_send_r;
    assign tx_data    = tx_data_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

    // FIFO storage; contents are not reset, occupancy tracking makes them irrelevant.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            count_r    <= {(DEPTH_LOG2+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Read FSM state and registered transmitter outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            tx_send_r <= 1'b0;
            tx_data_r <= 8'h00;
            lf_done_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            tx_send_r <= tx_send_s;
            tx_data_r <= tx_data_s;
            lf_done_r <= lf_done_s;
        end
    end

    // Next-state logic; HOLD spends one cycle ignoring tx_ready while the transmitter drops it.
    always_comb begin
        state_s   = state_r;
        tx_send_s = 1'b0;
        tx_data_s = tx_data_r;
        lf_done_s = lf_done_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && tx_ready) begin
                    pop_s     = 1'b1;
                    tx_data_s = mem_r[rd_ptr_r];
                    tx_send_s = 1'b1;
                    lf_done_s = 1'b0;
                    state_s   = ST_HOLD;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                state_s = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (tx_ready) begin
                    if ((CR_EXPAND == 1'b1) && (tx_data_r == 8'h0D) && !lf_done_r) begin
                        state_s = ST_SEND_LF;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_WAIT_RDY;
                end
            end
            ST_SEND_LF: begin
                tx_data_s = 8'h0A;
                tx_send_s = 1'b1;
                lf_done_s = 1'b1;
                state_s   = ST_HOLD;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule
